// File: rtl/loop_count_stack_pkg.sv
// Shared types for the loop-count stack: command priority encoding and error bit positions.
package loop_stack_pkg;

   typedef enum logic [1:0] {
      CMD_NONE = 2'd0,
      CMD_POP  = 2'd1,
      CMD_PUSH = 2'd2,
      CMD_DEC  = 2'd3
   } cmd_e;

   localparam int ERR_OVF = 0;
   localparam int ERR_UNF = 1;

   // One command per cycle: Pop beats Push beats Dec; the losers are dropped.
   function automatic cmd_e decode_cmd(input logic pop, input logic push, input logic dec);
      if (pop)       return CMD_POP;
      else if (push) return CMD_PUSH;
      else if (dec)  return CMD_DEC;
      else           return CMD_NONE;
   endfunction

endpackage

// File: rtl/loop_count_stack_if.sv
// Decode-side commands and branch-side status of the loop-count stack.
// Optional error port pair (Err_clr/Err) exists only when LOOP_STACK_ERR_EN is defined.
interface loop_count_stack_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   // Commands are level-sampled at each rising clock edge; there is no valid/ready
   // handshake: the stack accepts or ignores every command in the cycle it is seen.
   logic             Push;
   logic [WIDTH-1:0] Count_in;
   logic             Dec;
   logic             Pop;
   logic [WIDTH-1:0] Count_out;
   logic [LW-1:0]    Level;
   logic             Empty;
   logic             Full;
   logic             Zero;
   logic             Done;
`ifdef LOOP_STACK_ERR_EN
   logic             Err_clr;
   logic [1:0]       Err;

   modport master (output Push, Count_in, Dec, Pop, Err_clr,
                   input  Count_out, Level, Empty, Full, Zero, Done, Err);
   modport slave  (input  Push, Count_in, Dec, Pop, Err_clr,
                   output Count_out, Level, Empty, Full, Zero, Done, Err);
`else
   modport master (output Push, Count_in, Dec, Pop,
                   input  Count_out, Level, Empty, Full, Zero, Done);
   modport slave  (input  Push, Count_in, Dec, Pop,
                   output Count_out, Level, Empty, Full, Zero, Done);
`endif
endinterface

// File: rtl/loop_count_stack_sat_decrement.sv
// Saturating decrement of the top loop count: max(T-STEP, 0), plus a T==0 flag.
module sat_decrement #(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input  logic [WIDTH-1:0] t_i,
   output logic [WIDTH-1:0] dec_o,
   output logic             is_zero_o
);
   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   assign dec_o     = (t_i < STEP_W) ? '0 : (t_i - STEP_W);
   assign is_zero_o = (t_i == '0);
endmodule

// File: rtl/loop_count_stack.sv
// Hardware loop-count stack: DEPTH nested counters, top decremented by STEP, auto-pop on exhaustion.
// Build option: define LOOP_STACK_ERR_EN to add the sticky overflow/underflow register (Err/Err_clr).
module loop_count_stack
   import loop_stack_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int STEP  = 1
) (
   input logic               Clk,
   input logic               Rst_n,
   loop_count_stack_if.slave bus
);
   localparam int LW = $clog2(DEPTH) + 1;
   localparam int IW = $clog2(DEPTH);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [WIDTH-1:0] slot_q [DEPTH];
   logic [LW-1:0]    level_q, level_d;
   logic [WIDTH-1:0] count_out_q, count_out_d;
   logic             empty_q, full_q, zero_q, done_q, done_d;

   cmd_e             cmd;
   logic             wr_en;
   logic [IW-1:0]    wr_idx, top_idx, rd_idx;
   logic [WIDTH-1:0] wr_data, dec_val;
   logic             top_zero;

   // count_out_q always mirrors the top slot, so it feeds the decrementer directly.
   sat_decrement #(.WIDTH(WIDTH), .STEP(STEP)) u_sat_decrement (
      .t_i       (count_out_q),
      .dec_o     (dec_val),
      .is_zero_o (top_zero)
   );

   assign top_idx = IW'(level_q - LW'(1));

   always_comb begin
      cmd     = decode_cmd(bus.Pop, bus.Push, bus.Dec);
      level_d = level_q;
      wr_en   = 1'b0;
      wr_idx  = '0;
      wr_data = '0;
      done_d  = 1'b0;
      case (cmd)
         CMD_POP: if (!empty_q) level_d = level_q - LW'(1);
         CMD_PUSH: if (!full_q) begin
            wr_en   = 1'b1;
            wr_idx  = IW'(level_q);
            wr_data = bus.Count_in;
            level_d = level_q + LW'(1);
         end
         CMD_DEC: if (!empty_q) begin
            if (top_zero) begin
               level_d = level_q - LW'(1);
               done_d  = 1'b1;
            end else begin
               wr_en   = 1'b1;
               wr_idx  = top_idx;
               wr_data = dec_val;
            end
         end
         default: ;
      endcase

      // Next top value must account for a write landing in the same cycle.
      rd_idx = IW'(level_d - LW'(1));
      if (level_d == '0)                 count_out_d = '0;
      else if (wr_en && wr_idx == rd_idx) count_out_d = wr_data;
      else                               count_out_d = slot_q[rd_idx];
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
         level_q     <= '0;
         count_out_q <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         zero_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         if (wr_en) slot_q[wr_idx] <= wr_data;
         level_q     <= level_d;
         count_out_q <= count_out_d;
         empty_q     <= (level_d == '0);
         full_q      <= (level_d == FULL_LVL);
         zero_q      <= (level_d != '0) && (count_out_d == '0);
         done_q      <= done_d;
      end
   end

   assign bus.Count_out = count_out_q;
   assign bus.Level     = level_q;
   assign bus.Empty     = empty_q;
   assign bus.Full      = full_q;
   assign bus.Zero      = zero_q;
   assign bus.Done      = done_q;

`ifdef LOOP_STACK_ERR_EN
   logic [1:0] err_q, err_d;

   // Sticky flags; a same-cycle set wins over Err_clr.
   always_comb begin
      err_d = err_q;
      if (bus.Err_clr) err_d = '0;
      if (cmd == CMD_PUSH && full_q) err_d[ERR_OVF] = 1'b1;
      if ((cmd == CMD_POP || cmd == CMD_DEC) && empty_q) err_d[ERR_UNF] = 1'b1;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) err_q <= '0;
      else        err_q <= err_d;
   end

   assign bus.Err = err_q;
`endif
endmodule

// File: tb/tb_loop_count_stack.sv
// Directed bench for loop_count_stack: STEP=1 and STEP=4 instances, table vectors plus corner sequences.
module tb_loop_count_stack;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int LW = $clog2(D) + 1;
   localparam int OW = W + LW + 4;

   logic Clk;
   logic Rst_n;
   int   checks = 0;
   int   errors = 0;
   logic [OW-1:0] exp_q[$];

   loop_count_stack_if #(.WIDTH(W), .DEPTH(D)) bus1 ();
   loop_count_stack_if #(.WIDTH(W), .DEPTH(D)) bus4 ();

   loop_count_stack #(.WIDTH(W), .DEPTH(D), .STEP(1)) u_dut1 (.Clk(Clk), .Rst_n(Rst_n), .bus(bus1));
   loop_count_stack #(.WIDTH(W), .DEPTH(D), .STEP(4)) u_dut4 (.Clk(Clk), .Rst_n(Rst_n), .bus(bus4));

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1);
   end

   typedef struct {
      logic         push;
      logic [W-1:0] cin;
      logic         dec;
      logic         pop;
      logic [OW-1:0] exp;
   } vec_t;
   vec_t vecs[$];

   function automatic logic [OW-1:0] pk(input int cnt, input int lvl, input bit e, input bit f,
                                        input bit z, input bit d);
      return {W'(cnt), LW'(lvl), e, f, z, d};
   endfunction

   function automatic logic [OW-1:0] obs(input bit sel4);
      if (sel4) return {bus4.Count_out, bus4.Level, bus4.Empty, bus4.Full, bus4.Zero, bus4.Done};
      else      return {bus1.Count_out, bus1.Level, bus1.Empty, bus1.Full, bus1.Zero, bus1.Done};
   endfunction

   task automatic add(input logic push, input int cin, input logic dec, input logic pop,
                      input logic [OW-1:0] exp);
      vec_t v;
      v.push = push; v.cin = W'(cin); v.dec = dec; v.pop = pop; v.exp = exp;
      vecs.push_back(v);
   endtask

   // driver
   task automatic drive(input bit sel4, input logic push, input int cin, input logic dec,
                        input logic pop);
      if (sel4) begin
         bus4.Push = push; bus4.Count_in = W'(cin); bus4.Dec = dec; bus4.Pop = pop;
      end else begin
         bus1.Push = push; bus1.Count_in = W'(cin); bus1.Dec = dec; bus1.Pop = pop;
      end
   endtask

   // scoreboard
   task automatic check_now(input string name, input bit sel4, input logic [OW-1:0] exp);
      logic [OW-1:0] got, e;
      exp_q.push_back(exp);
      got = obs(sel4);
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL %s: got {cnt,lvl,empty,full,zero,done}=%0d,%0d,%b%b%b%b expected %0d,%0d,%b%b%b%b",
                  name, got[OW-1 -: W], got[LW+3:4], got[3], got[2], got[1], got[0],
                  e[OW-1 -: W], e[LW+3:4], e[3], e[2], e[1], e[0]);
      end
   endtask

   task automatic step_check(input string name, input bit sel4, input logic [OW-1:0] exp);
      @(posedge Clk);
      #1;
      drive(sel4, 1'b0, 0, 1'b0, 1'b0);
      check_now(name, sel4, exp);
   endtask

`ifdef LOOP_STACK_ERR_EN
   task automatic err_step(input string name, input logic clr, input logic [1:0] exp);
      bus1.Err_clr = clr;
      @(posedge Clk);
      #1;
      drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
      bus1.Err_clr = 1'b0;
      checks++;
      if (bus1.Err !== exp) begin
         errors++;
         $display("FAIL %s: got Err=%b expected %b", name, bus1.Err, exp);
      end
   endtask
`endif

   initial begin
      Rst_n = 1'b0;
      drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
`ifdef LOOP_STACK_ERR_EN
      bus1.Err_clr = 1'b0;
      bus4.Err_clr = 1'b0;
`endif

      // push, cin, dec, pop, expected {cnt, lvl, empty, full, zero, done}
      add(1, 3,  0, 0, pk(3, 1, 0, 0, 0, 0));
      add(0, 0,  1, 0, pk(2, 1, 0, 0, 0, 0));
      add(0, 0,  1, 0, pk(1, 1, 0, 0, 0, 0));
      add(0, 0,  1, 0, pk(0, 1, 0, 0, 1, 0));
      add(0, 0,  1, 0, pk(0, 0, 1, 0, 0, 1));
      add(0, 0,  0, 0, pk(0, 0, 1, 0, 0, 0));
      add(0, 0,  1, 0, pk(0, 0, 1, 0, 0, 0));
      add(0, 0,  0, 1, pk(0, 0, 1, 0, 0, 0));
      add(1, 2,  0, 0, pk(2, 1, 0, 0, 0, 0));
      add(1, 1,  0, 0, pk(1, 2, 0, 0, 0, 0));
      add(0, 0,  1, 0, pk(0, 2, 0, 0, 1, 0));
      add(0, 0,  1, 0, pk(2, 1, 0, 0, 0, 1));
      add(0, 0,  0, 0, pk(2, 1, 0, 0, 0, 0));
      add(0, 0,  0, 1, pk(0, 0, 1, 0, 0, 0));
      add(1, 5,  0, 0, pk(5, 1, 0, 0, 0, 0));
      add(1, 7,  1, 0, pk(7, 2, 0, 0, 0, 0));
      add(0, 0,  0, 1, pk(5, 1, 0, 0, 0, 0));
      add(1, 9,  0, 1, pk(0, 0, 1, 0, 0, 0));
      add(1, 10, 0, 0, pk(10, 1, 0, 0, 0, 0));
      add(1, 20, 0, 0, pk(20, 2, 0, 0, 0, 0));
      add(1, 30, 0, 0, pk(30, 3, 0, 0, 0, 0));
      add(1, 40, 0, 0, pk(40, 4, 0, 1, 0, 0));
      add(1, 9,  0, 0, pk(40, 4, 0, 1, 0, 0));
      add(0, 0,  1, 0, pk(39, 4, 0, 1, 0, 0));
      add(0, 0,  0, 1, pk(30, 3, 0, 0, 0, 0));
      add(0, 0,  1, 1, pk(20, 2, 0, 0, 0, 0));
      add(0, 0,  0, 1, pk(10, 1, 0, 0, 0, 0));
      add(0, 0,  0, 1, pk(0, 0, 1, 0, 0, 0));

      repeat (2) @(posedge Clk);
      #1;
      check_now("reset_state", 1'b0, pk(0, 0, 1, 0, 0, 0));
      check_now("reset_state_s4", 1'b1, pk(0, 0, 1, 0, 0, 0));
      Rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(1'b0, vecs[i].push, int'(vecs[i].cin), vecs[i].dec, vecs[i].pop);
         step_check($sformatf("vec%0d", i), 1'b0, vecs[i].exp);
      end

      // asynchronous reset mid-stream at Level=3
      drive(1'b0, 1'b1, 11, 1'b0, 1'b0); step_check("mid_push1", 1'b0, pk(11, 1, 0, 0, 0, 0));
      drive(1'b0, 1'b1, 12, 1'b0, 1'b0); step_check("mid_push2", 1'b0, pk(12, 2, 0, 0, 0, 0));
      drive(1'b0, 1'b1, 13, 1'b0, 1'b0); step_check("mid_push3", 1'b0, pk(13, 3, 0, 0, 0, 0));
      drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
      #2 Rst_n = 1'b0;
      #1 check_now("async_reset", 1'b0, pk(0, 0, 1, 0, 0, 0));
      drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
      @(posedge Clk);
      #1 Rst_n = 1'b1;
      step_check("after_reset", 1'b0, pk(0, 0, 1, 0, 0, 0));

      // STEP=4: 6 -> 2 -> 0 (saturate) -> auto-pop
      drive(1'b1, 1'b1, 6, 1'b0, 1'b0); step_check("s4_push6", 1'b1, pk(6, 1, 0, 0, 0, 0));
      drive(1'b1, 1'b0, 0, 1'b1, 1'b0); step_check("s4_dec_2", 1'b1, pk(2, 1, 0, 0, 0, 0));
      drive(1'b1, 1'b0, 0, 1'b1, 1'b0); step_check("s4_dec_sat", 1'b1, pk(0, 1, 0, 0, 1, 0));
      drive(1'b1, 1'b0, 0, 1'b1, 1'b0); step_check("s4_dec_done", 1'b1, pk(0, 0, 1, 0, 0, 1));
      step_check("s4_idle", 1'b1, pk(0, 0, 1, 0, 0, 0));

`ifdef LOOP_STACK_ERR_EN
      drive(1'b0, 1'b0, 0, 1'b1, 1'b0); err_step("err_unf_dec", 1'b0, 2'b10);
      err_step("err_clr", 1'b1, 2'b00);
      for (int i = 0; i < D; i++) begin
         drive(1'b0, 1'b1, i + 1, 1'b0, 1'b0);
         err_step($sformatf("err_fill%0d", i), 1'b0, 2'b00);
      end
      drive(1'b0, 1'b1, 9, 1'b0, 1'b0); err_step("err_ovf", 1'b0, 2'b01);
      drive(1'b0, 1'b1, 9, 1'b0, 1'b0); err_step("err_set_over_clr", 1'b1, 2'b01);
      err_step("err_clr2", 1'b1, 2'b00);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
